instr_fetch: RTL and testbench

Instruction fetch stage that drives the unified instruction/data block RAM and delivers one 32-bit instruction word per handshake to the downstream execute stage. It owns the PC and issues single-word reads to the synchronous RAM, which has one cycle of read latency. It holds each fetched word with a valid/ready handshake, accepts PC redirects from execute, and flags illegal fetch addresses. A step_en input lets the board pace fetches from a slow tick without a derived clock.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction constants, reset PC and fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned MEM_WORDS_DEF    = 3000;
  localparam int unsigned IDX_W_DEF        = 12;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  // A fetch address must be word aligned and fall inside the RAM.
  function automatic logic pc_is_legal(input logic [31:0] pc, input int unsigned words);
    return (pc[1:0] == 2'b00) && (pc[31:2] < 30'(words));
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads the shared block RAM one word at a
// time and presents each instruction to execute through a valid/ready handshake.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             step_en,
  output logic             mem_ren,
  output logic [IDX_W-1:0] mem_idx,
  input  logic [31:0]      mem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ir,
  output logic [31:0]      out_pc,
  output logic             fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         out_valid_d;
  logic [31:0]  out_ir_d;
  logic [31:0]  out_pc_d;
  logic         fault_d;
  logic         pc_legal;

  assign mem_idx  = pc_q[IDX_W+1:2];
  assign pc_legal = pc_is_legal(pc_q, MEM_WORDS);

  // State, PC and output registers.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      out_valid <= 1'b0;
      out_ir    <= NOP_INSTR;
      out_pc    <= RESET_PC;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_valid <= out_valid_d;
      out_ir    <= out_ir_d;
      out_pc    <= out_pc_d;
      fault     <= fault_d;
    end
  end

  // Next-state logic; a redirect outranks everything except a latched fault.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid;
    out_ir_d    = out_ir;
    out_pc_d    = out_pc;
    fault_d     = fault;
    mem_ren     = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (!pc_legal) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (step_en) begin
          mem_ren = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          // RAM data arriving this cycle belongs to the abandoned path.
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
          state_d     = FETCH;
        end else begin
          out_ir_d    = mem_rdata;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
          state_d     = FETCH;
        end else if (out_ready) begin
          pc_d        = pc_q + 32'd4;
          out_valid_d = 1'b0;
          state_d     = FETCH;
        end
      end

      FAULT: begin
        fault_d     = 1'b1;
        out_valid_d = 1'b0;
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle-latency RAM model.
module tb_instr_fetch;

  localparam int unsigned IDX_W = 12;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             step_en;
  logic             mem_ren;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_rdata = '0;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_ir;
  logic [31:0]      out_pc;
  logic             fault;

  int n_cmp   = 0;
  int n_err   = 0;
  int ren_cnt = 0;
  int bad_ren = 0;

  instr_fetch #(
    .MEM_WORDS(3000),
    .IDX_W    (IDX_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .step_en       (step_en),
    .mem_ren       (mem_ren),
    .mem_idx       (mem_idx),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ir        (out_ir),
    .out_pc        (out_pc),
    .fault         (fault)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] ram_word(input logic [IDX_W-1:0] idx);
    case (idx)
      12'd0:   return 32'h0050_0093;
      12'd1:   return 32'h0000_0007;
      12'd2:   return 32'h0000_006F;
      default: return {20'hCAFE0, idx};
    endcase
  endfunction

  // RAM with one cycle of read latency; also tallies read strobes.
  always @(posedge clk_in) begin
    if (mem_ren) begin
      mem_rdata <= ram_word(mem_idx);
      ren_cnt   <= ren_cnt + 1;
      if (!step_en) bad_ren <= bad_ren + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #2;
  endtask

  task automatic wait_ren(input int max);
    int n = 0;
    while (!mem_ren && n < max) begin
      step();
      n++;
    end
    check("ren_timeout", 32'(mem_ren), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base;
    int bad0;
    reset = 1'b1; step_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b0;
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ir",    out_ir,         32'h0000_0013);
    check("rst_pc",    out_pc,         32'd0);
    check("rst_fault", 32'(fault),     32'd0);
    check("rst_ren",   32'(mem_ren),   32'd0);

    // Sequential fetch of words 0..2 with no backpressure
    reset = 1'b0; step_en = 1'b1; out_ready = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) wait_ren(5);
      else check("seq_ren_period", 32'(mem_ren), 32'd1);
      check("seq_idx", 32'(mem_idx), 32'(i));
      step();
      check("seq_wait_valid", 32'(out_valid), 32'd0);
      step();
      check("seq_valid", 32'(out_valid), 32'd1);
      check("seq_ir", out_ir, ram_word(IDX_W'(i)));
      check("seq_pc", out_pc, 32'(4 * i));
      step();
    end

    // Backpressure holds the word and blocks new reads
    reset = 1'b1; step();
    reset = 1'b0; out_ready = 1'b0; #1;
    wait_ren(5);
    step(); step();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_pc0",   out_pc,         32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("bp_hold_ir",  out_ir,            32'h0050_0093);
      check("bp_hold_pc",  out_pc,            32'd0);
      check("bp_hold_ren", 32'(mem_ren),      32'd0);
    end
    out_ready = 1'b1;
    step(); #1;
    check("bp_next_ren", 32'(mem_ren), 32'd1);
    check("bp_next_idx", 32'(mem_idx), 32'd1);
    step(); step();
    check("bp_next_pc", out_pc, 32'd4);
    check("bp_next_ir", out_ir, 32'h0000_0007);

    // step_en pulsed one cycle in five
    step_en = 1'b0;
    base = ren_cnt; bad0 = bad_ren;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 5; c++) begin
        step_en = (c == 4);
        step();
      end
    end
    step_en = 1'b0;
    step(); step();
    check("pulse_ren_count", 32'(ren_cnt - base), 32'd4);
    check("pulse_bad_ren",   32'(bad_ren - bad0), 32'd0);

    // Redirect while a read is in flight
    step_en = 1'b1; #1;
    wait_ren(5);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0; #1;
    check("rdw_valid", 32'(out_valid), 32'd0);
    check("rdw_ren",   32'(mem_ren),   32'd1);
    check("rdw_idx",   32'(mem_idx),   32'd16);
    step(); step();
    check("rdw_pc", out_pc, 32'h40);
    check("rdw_ir", out_ir, ram_word(12'd16));

    // Redirect coinciding with a HOLD handshake
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0; #1;
    check("rdh_idx",   32'(mem_idx),   32'd32);
    check("rdh_valid", 32'(out_valid), 32'd0);
    step(); step();
    check("rdh_pc", out_pc, 32'h80);
    check("rdh_ir", out_ir, ram_word(12'd32));
    step();

    // Misaligned redirect leads to a sticky fault
    redirect_valid = 1'b1; redirect_pc = 32'h42; #1;
    check("mis_redir_ren", 32'(mem_ren), 32'd0);
    step();
    redirect_valid = 1'b0; #1;
    check("mis_illegal_ren", 32'(mem_ren), 32'd0);
    base = ren_cnt;
    step();
    check("mis_fault", 32'(fault),     32'd1);
    check("mis_valid", 32'(out_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(); step();
    redirect_valid = 1'b0; step();
    check("fault_sticky",  32'(fault),           32'd1);
    check("fault_no_read", 32'(ren_cnt - base),  32'd0);

    reset = 1'b1; step_en = 1'b0; step();
    reset = 1'b0; #1;
    check("rst_clears_fault", 32'(fault), 32'd0);

    // Run off the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'd11992;
    step();
    redirect_valid = 1'b0; step_en = 1'b1; #1;
    check("eom_idx0", 32'(mem_idx), 32'd2998);
    step(); step();
    check("eom_pc0", out_pc, 32'd11992);
    step(); #1;
    check("eom_idx1", 32'(mem_idx), 32'd2999);
    step(); step();
    check("eom_pc1", out_pc, 32'd11996);
    check("eom_ir1", out_ir, ram_word(12'd2999));
    step(); #1;
    check("eom_no_ren", 32'(mem_ren), 32'd0);
    step();
    check("eom_fault", 32'(fault), 32'd1);

    // Reset during WAIT drops the in-flight read
    reset = 1'b1; step();
    reset = 1'b0; #1;
    check("rw_ren", 32'(mem_ren), 32'd1);
    step();
    reset = 1'b1; step_en = 1'b0;
    step();
    reset = 1'b0; #1;
    check("rw_valid", 32'(out_valid), 32'd0);
    check("rw_ir",    out_ir,         32'h0000_0013);
    check("rw_pc",    out_pc,         32'd0);
    step();
    check("rw_still_idle", 32'(out_valid), 32'd0);
    step_en = 1'b1; #1;
    check("rw_resume_ren", 32'(mem_ren), 32'd1);
    check("rw_resume_idx", 32'(mem_idx), 32'd0);
    step(); step();
    check("rw_resume_valid", 32'(out_valid), 32'd1);
    check("rw_resume_ir",    out_ir,         32'h0050_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
